dem_switching_block: RTL and testbench
======================================

Name: dem_switching_block

Overview:
- First-level switching block of the tree-structured DEM encoder.
- Consumes the 1-bit PN sequence from the upstream PN generator.
- Each sample, splits an input thermometer count into two half-counts, top and bottom, for the two child branches; the PN bit randomises the sign of the odd-code residue.
- Registered output (1-cycle latency); tracks the running switching imbalance and flags out-of-range codes.

Parameters:
- CODE_W, 4, child code width; parent code_i is CODE_W+1 bits, legal range 0..2**CODE_W.
- ACC_W, 8, width of the signed imbalance accumulator imb_o.

Ports:
- clk_i  input  1  system clock, rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- valid_i  input  1  code_i and pn_i are valid this cycle.
- code_i  input  CODE_W+1  parent element count, unsigned.
- pn_i  input  1  PN bit from the upstream generator; sampled only when valid_i=1.
- valid_o  output  1  top_o/bot_o hold a new result.
- top_o  output  CODE_W  count for the top child branch.
- bot_o  output  CODE_W  count for the bottom child branch.
- sw_o  output  2  switching sequence of the last sample: 2'b01=+1, 2'b11=-1, 2'b00=0.
- imb_o  output  ACC_W  signed running sum of applied s values.
- range_err_o  output  1  sticky flag: a code above 2**CODE_W was received.

Behaviour:
- Reset (async assert, sync release):
  - valid_o=0, top_o=0, bot_o=0, sw_o=2'b00, imb_o=0, range_err_o=0.
  - Reset mid-stream discards the in-flight sample; the first result after release needs a fresh valid_i.
- Clamp: c = min(code_i, 2**CODE_W). If code_i > 2**CODE_W, set range_err_o=1; it holds until reset.
- Switching sequence s:
  - c even: s=0.
  - c odd: s=+1 if pn_i=1, s=-1 if pn_i=0.
- Outputs, with arithmetic at CODE_W+2 bits and no truncation loss:
  - top = (c+s)/2
  - bot = (c-s)/2
  - Invariant: top+bot=c and |top-bot|<=1.
- Boundaries:
  - c=0 gives 0/0.
  - c=2**CODE_W gives 2**(CODE_W-1) each (even, s=0).
  - c=2**CODE_W-1 with s=+1 gives top=2**(CODE_W-1), which fits in CODE_W bits.
- Latency: results appear the cycle after valid_i=1 (1-cycle pipeline), with valid_o=1 for exactly that cycle.
- valid_i=0:
  - valid_o=0 next cycle.
  - top_o, bot_o and sw_o hold their previous values.
  - imb_o is unchanged.
- Accumulator:
  - Updated with s on every valid sample: imb_o += s.
  - Saturates at +(2**(ACC_W-1)-1) and -(2**(ACC_W-1)), with no wrap-around.
  - Even codes leave it unchanged.
- No backpressure: every valid_i sample must be accepted; the downstream element array consumes every cycle.

Optional Feature:
- Macro DEM_SHAPING_EN.
- Defined (first-order noise-shaped switching), for odd c:
  - imb_o>0: s=-1.
  - imb_o<0: s=+1.
  - imb_o==0: s is taken from pn_i as in the default mode.
  - Keeps |imb_o|<=1 in steady state, pushing mismatch error to high frequency. pn_i is still used to break ties.
- Undefined: s depends only on pn_i, as specified above. Same latency and ports in both builds.

Test Plan:
- Reset check: assert reset_i with valid_i=1, code_i=9 -> all outputs 0. Release, apply code_i=9, pn_i=1 -> next cycle valid_o=1, top_o=5, bot_o=4, sw_o=01, imb_o=1.
- Even/odd sweep: code_i 0..16 with alternating pn_i -> top_o+bot_o==code_i and |top_o-bot_o|<=1 for all; code_i=16 gives 8/8 with sw_o=00.
- Range error: code_i=20 -> top_o=8, bot_o=8, range_err_o=1. Follow with code_i=3 -> range_err_o stays 1 until reset.
- Saturation (ACC_W=8, DEM_SHAPING_EN undefined): 200 samples of code_i=1, pn_i=1 -> imb_o stops at 127. Then 300 samples with pn_i=0 -> imb_o stops at -128.
- Valid gaps: valid_i pattern 1,0,0,1 with codes 7,x,x,2 -> valid_o 0,1,0,0,1. Outputs hold 4/3 (pn_i=1) through the gaps, then 1/1 with sw_o=00. imb_o does not change during the gaps.
- Shaping (DEM_SHAPING_EN defined): code_i=5 for 8 samples with pn_i fixed at 1 -> sw_o alternates 01,11,01,11,... and imb_o alternates 1,0,1,0,...

Source files
------------

// File: rtl/dem_switching_block.sv
// First-level DEM tree switching block: splits a parent count into top/bottom halves,
// with the odd-code residue sign chosen by the PN bit. Optional macro DEM_SHAPING_EN.
module dem_switching_block #(
  parameter int CODE_W = 4,
  parameter int ACC_W  = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              valid_i,
  input  logic [CODE_W:0]   code_i,
  input  logic              pn_i,
  output logic              valid_o,
  output logic [CODE_W-1:0] top_o,
  output logic [CODE_W-1:0] bot_o,
  output logic [1:0]        sw_o,
  output logic [ACC_W-1:0]  imb_o,
  output logic              range_err_o
);

  localparam int EXT_W = CODE_W + 2;

  localparam logic [CODE_W:0]  CODE_MAX  = {1'b1, {CODE_W{1'b0}}};
  localparam logic [EXT_W-1:0] EXT_ONE   = {{(EXT_W-1){1'b0}}, 1'b1};
  localparam logic [EXT_W-1:0] EXT_MINUS = {EXT_W{1'b1}};
  localparam logic [EXT_W-1:0] EXT_ZERO  = {EXT_W{1'b0}};
  localparam logic [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] ACC_ONE   = {{(ACC_W-1){1'b0}}, 1'b1};

  logic              valid_r;
  logic [CODE_W-1:0] top_r;
  logic [CODE_W-1:0] bot_r;
  logic [1:0]        sw_r;
  logic [ACC_W-1:0]  imb_r;
  logic              err_r;

  logic [CODE_W:0]   code_c_s;
  logic              over_s;
  logic              odd_s;
  logic              s_pos_s;
  logic [EXT_W-1:0]  s_ext_s;
  logic [EXT_W-1:0]  top_sum_s;
  logic [EXT_W-1:0]  bot_sum_s;
  logic [1:0]        sw_next_s;
  logic [ACC_W-1:0]  imb_next_s;

  // Clamp the incoming count to the legal maximum and flag overflow
  always_comb begin
    over_s   = 1'b0;
    code_c_s = code_i;
    if (code_i > CODE_MAX) begin
      over_s   = 1'b1;
      code_c_s = CODE_MAX;
    end else begin
      over_s   = 1'b0;
      code_c_s = code_i;
    end
  end

  assign odd_s = code_c_s[0];

`ifdef DEM_SHAPING_EN
  // Noise-shaped sign: steer the residue against the running imbalance, PN breaks ties
  always_comb begin
    s_pos_s = pn_i;
    if (imb_r == {ACC_W{1'b0}}) begin
      s_pos_s = pn_i;
    end else if (imb_r[ACC_W-1]) begin
      s_pos_s = 1'b1;
    end else begin
      s_pos_s = 1'b0;
    end
  end
`else
  assign s_pos_s = pn_i;
`endif

  // Residue sign, child counts at extended width, and saturating imbalance update
  always_comb begin
    s_ext_s    = EXT_ZERO;
    sw_next_s  = 2'b00;
    imb_next_s = imb_r;
    case ({odd_s, s_pos_s})
      2'b11: begin
        s_ext_s   = EXT_ONE;
        sw_next_s = 2'b01;
        if (imb_r != ACC_MAX) imb_next_s = imb_r + ACC_ONE;
        else                  imb_next_s = imb_r;
      end
      2'b10: begin
        s_ext_s   = EXT_MINUS;
        sw_next_s = 2'b11;
        if (imb_r != ACC_MIN) imb_next_s = imb_r - ACC_ONE;
        else                  imb_next_s = imb_r;
      end
      default: begin
        s_ext_s    = EXT_ZERO;
        sw_next_s  = 2'b00;
        imb_next_s = imb_r;
      end
    endcase
    // c+s and c-s are always even and non-negative, so the halving is exact
    top_sum_s = EXT_W'(code_c_s) + s_ext_s;
    bot_sum_s = EXT_W'(code_c_s) - s_ext_s;
  end

  // Output pipeline register; results hold across invalid cycles
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_r <= 1'b0;
      top_r   <= {CODE_W{1'b0}};
      bot_r   <= {CODE_W{1'b0}};
      sw_r    <= 2'b00;
      imb_r   <= {ACC_W{1'b0}};
      err_r   <= 1'b0;
    end else if (valid_i) begin
      valid_r <= 1'b1;
      top_r   <= CODE_W'(top_sum_s >> 1);
      bot_r   <= CODE_W'(bot_sum_s >> 1);
      sw_r    <= sw_next_s;
      imb_r   <= imb_next_s;
      err_r   <= err_r | over_s;
    end else begin
      valid_r <= 1'b0;
    end
  end

  assign valid_o     = valid_r;
  assign top_o       = top_r;
  assign bot_o       = bot_r;
  assign sw_o        = sw_r;
  assign imb_o       = imb_r;
  assign range_err_o = err_r;

endmodule

// File: tb/tb_dem_switching_block.sv
// Self-checking bench for dem_switching_block: directed steps plus random samples
// against an integer reference model of the split/sign/accumulate rules.
module tb_dem_switching_block;

  localparam int CODE_W = 4;
  localparam int ACC_W  = 8;
  localparam int CMAX   = 1 << CODE_W;
  localparam int IMAX   = (1 << (ACC_W-1)) - 1;
  localparam int IMIN   = -(1 << (ACC_W-1));

  logic              clk_i = 1'b0;
  logic              reset_i = 1'b1;
  logic              valid_i = 1'b0;
  logic [CODE_W:0]   code_i = '0;
  logic              pn_i = 1'b0;
  logic              valid_o;
  logic [CODE_W-1:0] top_o;
  logic [CODE_W-1:0] bot_o;
  logic [1:0]        sw_o;
  logic [ACC_W-1:0]  imb_o;
  logic              range_err_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  // reference model state
  int m_valid, m_top, m_bot, m_s, m_imb, m_err, m_c;

  dem_switching_block #(.CODE_W(CODE_W), .ACC_W(ACC_W)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .code_i(code_i), .pn_i(pn_i),
    .valid_o(valid_o), .top_o(top_o), .bot_o(bot_o), .sw_o(sw_o), .imb_o(imb_o),
    .range_err_o(range_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sw_code(input int s);
    if (s > 0)      return 1;
    else if (s < 0) return 3;
    else            return 0;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".valid"}, {31'd0, valid_o}, m_valid);
    check({tag, ".top"}, {28'd0, top_o}, m_top);
    check({tag, ".bot"}, {28'd0, bot_o}, m_bot);
    check({tag, ".sw"}, {30'd0, sw_o}, sw_code(m_s));
    check({tag, ".imb"}, $signed(imb_o), m_imb);
    check({tag, ".err"}, {31'd0, range_err_o}, m_err);
  endtask

  task automatic model_reset();
    m_valid = 0; m_top = 0; m_bot = 0; m_s = 0; m_imb = 0; m_err = 0; m_c = 0;
  endtask

  task automatic step(input bit v, input int code, input bit pn, input string tag);
    int c, s, top_v, bot_v;
    valid_i = v; code_i = code[CODE_W:0]; pn_i = pn;
    @(posedge clk_i); #1;
    if (v) begin
      c = (code > CMAX) ? CMAX : code;
      if (code > CMAX) m_err = 1;
      if (c % 2 == 0) s = 0;
`ifdef DEM_SHAPING_EN
      else if (m_imb > 0) s = -1;
      else if (m_imb < 0) s = 1;
`endif
      else s = pn ? 1 : -1;
      m_c = c; m_s = s;
      m_top = (c + s) / 2;
      m_bot = (c - s) / 2;
      m_imb = m_imb + s;
      if (m_imb > IMAX) m_imb = IMAX;
      if (m_imb < IMIN) m_imb = IMIN;
      m_valid = 1;
    end else begin
      m_valid = 0;
    end
    check_all(tag);
    if (v) begin
      top_v = int'(top_o); bot_v = int'(bot_o);
      check({tag, ".sum"}, top_v + bot_v, m_c);
      check({tag, ".diff_le1"}, ((top_v - bot_v) <= 1 && (bot_v - top_v) <= 1) ? 1 : 0, 1);
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1; valid_i = 1'b1; code_i = 5'd9; pn_i = 1'b1;
    @(posedge clk_i); @(posedge clk_i); #1;
    model_reset();
    check_all("reset");
    valid_i = 1'b0;
    #2 reset_i = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset();
    step(1'b0, 0, 1'b0, "idle_after_reset");
    step(1'b1, 9, 1'b1, "first9");
    check("first9.top_const", {28'd0, top_o}, 5);
    check("first9.bot_const", {28'd0, bot_o}, 4);

    for (int k = 0; k <= CMAX; k++) step(1'b1, k, k[0], "sweep");
    check("sweep16.top_const", {28'd0, top_o}, 8);
    check("sweep16.sw_const", {30'd0, sw_o}, 0);

    step(1'b1, 20, 1'b1, "range20");
    check("range20.err_const", {31'd0, range_err_o}, 1);
    step(1'b1, 3, 1'b1, "range_then3");
    check("range_then3.err_const", {31'd0, range_err_o}, 1);

    do_reset();
    step(1'b1, 7, 1'b1, "gap7");
    step(1'b0, 11, 1'b0, "gap_a");
    step(1'b0, 13, 1'b1, "gap_b");
    check("gap_hold.top_const", {28'd0, top_o}, 4);
    step(1'b1, 2, 1'b0, "gap2");
    step(1'b0, 0, 1'b0, "gap_end");

    for (int k = 0; k < 300; k++)
      step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 20)), 1'($urandom), "rand");

    do_reset();
`ifdef DEM_SHAPING_EN
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 5, 1'b1, "shape");
      check("shape.sw_alt", {30'd0, sw_o}, (k % 2 == 0) ? 1 : 3);
      check("shape.imb_alt", $signed(imb_o), (k % 2 == 0) ? 1 : 0);
    end
`else
    for (int k = 0; k < 200; k++) step(1'b1, 1, 1'b1, "sat_pos");
    check("sat_pos.const", $signed(imb_o), 127);
    for (int k = 0; k < 300; k++) step(1'b1, 1, 1'b0, "sat_neg");
    check("sat_neg.const", $signed(imb_o), -128);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
